// File: rtl/trap_capture.sv
// Trap-record queue: captures guest I/O cycles that violate the address map and serves them
// to the hypervisor through a 4-port window. Define TRAP_CAPTURE_READS_EN to also capture reads.
module trap_capture #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] BASE_PORT = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        io_violation,
    input  logic        trap_state,
    input  logic        virtual_enabled,
    output logic        capture_pending,
    output logic        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef TRAP_CAPTURE_READS_EN
    localparam logic READS_EN = 1'b1;
`else
    localparam logic READS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CYC, COMMIT} state_t;

    logic [3:0]       sync1_q, sync2_q;
    logic             s_iorq, s_rd, s_wr, s_m1;

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [15:0]      cyc_addr_q, cyc_addr_d;
    logic             cyc_dir_q, cyc_dir_d;
    logic             cyc_hyp_q, cyc_hyp_d;
    logic             cyc_viol_q, cyc_viol_d;
    logic [7:0]       cyc_data_q, cyc_data_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [15:0]      addr_mem [DEPTH];
    logic [7:0]       data_mem [DEPTH];
    logic             dir_mem  [DEPTH];

    logic             win_hit, viol_now, commit, mem_we;
    logic             do_flush, do_ovf_clr, do_pop, do_push;
    logic [7:0]       commit_data;
    logic             q_nonempty;
    logic [3:0]       count4;
    logic [15:0]      head_addr;

    // Synchronizers reset to the asserted level so a cycle already in flight at reset
    // release looks like "iorq low" and is held off by armed_q until iorq goes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= {iorq_n, rd_n, wr_n, m1_n};
            sync2_q <= sync1_q;
        end
    end

    assign s_iorq  = sync2_q[3];
    assign s_rd    = sync2_q[2];
    assign s_wr    = sync2_q[1];
    assign s_m1    = sync2_q[0];
    assign win_hit = (addr[7:2] == BASE_PORT[7:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            cyc_addr_q <= '0;
            cyc_dir_q  <= 1'b0;
            cyc_hyp_q  <= 1'b0;
            cyc_viol_q <= 1'b0;
            cyc_data_q <= 8'hFF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            cyc_addr_q <= cyc_addr_d;
            cyc_dir_q  <= cyc_dir_d;
            cyc_hyp_q  <= cyc_hyp_d;
            cyc_viol_q <= cyc_viol_d;
            cyc_data_q <= cyc_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            addr_mem[wr_ptr_q] <= cyc_addr_q;
            data_mem[wr_ptr_q] <= commit_data;
            dir_mem[wr_ptr_q]  <= cyc_dir_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | s_iorq;
        cyc_addr_d  = cyc_addr_q;
        cyc_dir_d   = cyc_dir_q;
        cyc_hyp_d   = cyc_hyp_q;
        cyc_viol_d  = cyc_viol_q;
        cyc_data_d  = cyc_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        commit      = 1'b0;
        mem_we      = 1'b0;
        viol_now    = io_violation & ~trap_state & virtual_enabled;
        commit_data = cyc_dir_q ? data_in : cyc_data_q;

        case (state_q)
            IDLE: begin
                if (armed_q && !s_iorq && (!s_rd || !s_wr) && s_m1) begin
                    state_d    = CYC;
                    cyc_addr_d = addr;
                    cyc_dir_d  = ~s_wr;
                    cyc_hyp_d  = trap_state & win_hit;
                    cyc_viol_d = viol_now;
                    cyc_data_d = s_wr ? 8'hFF : data_in;
                end
            end
            CYC: begin
                cyc_viol_d = cyc_viol_q | viol_now;
                if (cyc_dir_q) begin
                    cyc_data_d = data_in;
                end
                // The queue action lands on the edge that leaves CYC; COMMIT is a one-clk settle.
                if (s_iorq) begin
                    state_d = COMMIT;
                    commit  = 1'b1;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        do_flush   = commit & cyc_hyp_q & cyc_dir_q & (cyc_addr_q[1:0] == 2'd0) & commit_data[7];
        do_ovf_clr = commit & cyc_hyp_q & cyc_dir_q & (cyc_addr_q[1:0] == 2'd0) & commit_data[6];
        do_pop     = commit & cyc_hyp_q & ~cyc_dir_q & (cyc_addr_q[1:0] == 2'd3);
        do_push    = commit & ~cyc_hyp_q & (cyc_viol_q | viol_now) & (cyc_dir_q | READS_EN);

        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (do_pop) begin
            if (count_q != '0) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end else if (do_push) begin
            if (count_q == FULL_CNT) begin
                overflow_d = 1'b1;
            end else begin
                mem_we   = ~rst;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end
        if (do_ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    assign q_nonempty      = (count_q != '0);
    assign count4          = 4'(count_q);
    assign head_addr       = addr_mem[rd_ptr_q];
    assign capture_pending = q_nonempty;
    assign overflow        = overflow_q;
    assign data_oe         = ~rst & trap_state & ~iorq_n & ~rd_n & m1_n & win_hit;

    // Head is only popped at commit, so these muxes hold steady for the whole read cycle.
    always_comb begin
        data_out = 8'h00;
        if (data_oe) begin
            case (addr[1:0])
                2'd0:    data_out = {q_nonempty, overflow_q, q_nonempty & dir_mem[rd_ptr_q], 1'b0, count4};
                2'd1:    data_out = q_nonempty ? head_addr[7:0]     : 8'hFF;
                2'd2:    data_out = q_nonempty ? head_addr[15:8]    : 8'hFF;
                default: data_out = q_nonempty ? data_mem[rd_ptr_q] : 8'hFF;
            endcase
        end
    end

endmodule

// File: doc/trap_capture.md
# trap_capture

Synchronous trap-record queue for the Nabu MegaMapper CPLD. It records guest I/O cycles that raise an address violation while the guest runs untrapped, and hands them to the hypervisor. The hypervisor reads them through a small I/O port window after the NMI trap is taken. It is the consumer side of the violation/trap path: violations are written in from the bus, and the trap handler reads them out.

## Interface
- `DEPTH`, default 4: record queue entries; power of 2, 2..8.
- `BASE_PORT`, default 8'h40: hypervisor window base (low address byte, 4 ports, aligned to 4).
- `clk` in 1: CPLD clock, at least 4× the Z80 clock.
- `rst` in 1: reset, synchronous and active-high (one clock; reset is synchronous and active-high).
- `addr` in 16: Z80 address bus.
- `data_in` in 8: Z80 data bus, input path.
- `data_out` out 8: hypervisor read data.
- `data_oe` out 1: drive `data_out` onto the bus.
- `iorq_n`, `rd_n`, `wr_n`, `m1_n` in 1 each: raw Z80 strobes.
- `io_violation` in 1: guest I/O address violation, level, valid during the cycle.
- `trap_state` in 1: 1 = hypervisor/trap mode.
- `virtual_enabled` in 1: virtualization on.
- `capture_pending` out 1: queue non-empty.
- `overflow` out 1: sticky; a record was dropped.

## Operation
- Strobe sync: 2-FF synchronizers on `iorq_n`, `rd_n`, `wr_n`, `m1_n` produce s_iorq, s_rd, s_wr, s_m1.
- FSM states: IDLE, CYC, COMMIT.
  - IDLE→CYC when s_iorq=0 & (s_rd=0 | s_wr=0) & s_m1=1. On entry it latches `addr`, dir (1=write), hyp = trap_state & addr[7:2]==BASE_PORT[7:2].
  - s_m1=0 with s_iorq=0 is an interrupt acknowledge. It is ignored and the FSM stays in IDLE.
  - CYC: viol |= io_violation & !trap_state & virtual_enabled, every clk. For writes, data_in is sampled every clk and the last sample wins. When s_iorq=1, go to COMMIT.
  - COMMIT: perform the action below, then go to IDLE, always after exactly one clk.
- COMMIT actions:
  - Push when viol=1. Record = {addr, data, dir}; data = 8'hFF for reads.
  - Full at push: the record is dropped and `overflow` is set.
  - Hyp read of port +3: pop the head. Pop on empty is a no-op.
  - Hyp write of port +0: data bit7=1 flushes the queue; bit6=1 clears `overflow`.
  - Priority if events coincide: flush > pop > push.
  - Hyp accesses never push.
- Hypervisor read window (`trap_state`=1, `iorq_n`=0, `rd_n`=0, `m1_n`=1, addr[7:2] hit):
  - `data_oe` is combinational from the raw strobes.
  - `data_out` is muxed from registered state. Head contents are stable for the whole cycle because pops happen only at COMMIT.
  - +0 status: bit7 = non-empty, bit6 = overflow, bit5 = head dir, bits3:0 = count.
  - +1: head addr[7:0].
  - +2: head addr[15:8].
  - +3: head data.
  - On empty, +1..+3 read 8'hFF.
- Queue: circular buffer with wr/rd pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset values:
  - FSM = IDLE, queue empty (count = 0, pointers = 0).
  - `overflow`=0, `capture_pending`=0, `data_oe`=0, `data_out`=8'h00.

## Timing
- Cycle detect: CYC entered 3 clk after `iorq_n` falls (2 sync + 1 register).
- Commit: the push or pop lands 3 clk after `iorq_n` rises. `capture_pending`, count and `overflow` update on that same edge.
- Commit completes before the next Z80 I/O cycle can be detected, given the clk ≥ 4× Z80 clock rule.
- Back-to-back guest cycles each commit exactly once.
- `rst` asserted in CYC or COMMIT aborts the cycle with no push, pop or flag change. A cycle still in progress at reset release is ignored until s_iorq returns high.
- Push and pop come from distinct bus cycles, so they never share a clk in practice. The priority rule still governs if they do.

## Configuration
- `TRAP_CAPTURE_READS_EN` defined: violating read cycles push a record with dir=0 and data=8'hFF.
- Undefined: only write violations push. Read violations are ignored by this block, and NMI generation elsewhere is unaffected.
- Status bit5 is then always 1 when the queue is non-empty.

## Test plan
- Single write violation: reset, virtual_enabled=1, trap_state=0, guest OUT (0x12A5),0x3C with io_violation=1. Expect:
  - `capture_pending`=1 three clk after `iorq_n` rises.
  - With trap_state=1: IN 0x40 = 0xA1, 0x41 = 0xA5, 0x42 = 0x12, 0x43 = 0x3C.
  - Afterwards, IN 0x40 = 0x00.
- Fill and overflow: DEPTH=4, five write violations to 0x0010..0x0014. Expect:
  - count 4, `overflow`=1.
  - Pops return 0x10..0x13 in order, then the queue reads empty.
  - OUT 0x40,0x40 clears `overflow`.
- No capture when trapped or virtualization off: violations with trap_state=1, then with virtual_enabled=0. Expect count stays 0.
- Interrupt acknowledge (m1_n=0, iorq_n=0) with io_violation=1: no record, no `data_oe`.
- Read violation: guest IN from 0x0077 with violation. Expect:
  - With `TRAP_CAPTURE_READS_EN`: record addr 0x0077, data 0xFF, status bit5=0.
  - Without it: count 0.
- Reset mid-cycle: assert rst in CYC of a violating write. Expect no record, and the first cycle after reset is captured normally.
